// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and baud divider math.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int DATA_BITS = 8;

  // Clocks per oversample tick; the transmitter calls this with oversample = 1.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle tick every DIV clocks (every clock when DIV = 1).
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rstn,
  output logic tick
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  generate
    if (DIV < 1) begin : g_div_chk
      $error("uart_baud_tick: CLK_FREQ too low for BAUD*OVERSAMPLE");
    end
  endgenerate

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tc;

  assign tc   = (cnt_q == CW'(DIV - 1));
  assign tick = tc;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (tc) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, oversampled, with a single-entry valid/ready output register.
//  state | meaning
//  IDLE  | line idle, waiting for a low sample
//  START | counting to mid start bit to reject glitches
//  DATA  | sampling data bits at mid-bit, LSB first
//  STOP  | sampling stop bit; high completes the byte, low is a framing error
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rxd,
  input  logic                 rx_rdy,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  generate
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_os_chk
      $error("uart_rx: OVERSAMPLE must be even and at least 8");
    end
  endgenerate

  logic tick;

  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk (clk),
    .rstn(rstn),
    .tick(tick)
  );

  logic [1:0]           sync_q;
  logic                 rxd_s;
  uart_state_e          state_q, state_d;
  logic [SW-1:0]        s_cnt_q, s_cnt_d;
  logic [BW-1:0]        b_cnt_q, b_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;
  logic                 valid_q, valid_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 ovr_q, ovr_d;

  assign rxd_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    b_cnt_d = b_cnt_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rxd_s) begin
            state_d = START;
            s_cnt_d = '0;
          end
        end
        START: begin
          if (s_cnt_q == S_HALF) begin
            if (rxd_s) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              s_cnt_d = '0;
              b_cnt_d = '0;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (s_cnt_q == S_LAST) begin
            shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
            s_cnt_d = '0;
            if (b_cnt_q == B_LAST) state_d = STOP;
            else                   b_cnt_d = b_cnt_q + 1'b1;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (s_cnt_q == S_LAST) begin
            state_d = IDLE;
            done_d  = rxd_s;
            ferr_d  = !rxd_s;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // done_q marks the "complete" cycle; a same-cycle transfer frees the slot for the new byte.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovr_d   = 1'b0;
    if (valid_q && rx_rdy) valid_d = 1'b0;
    if (done_q) begin
      if (!valid_q || rx_rdy) begin
        valid_d = 1'b1;
        data_d  = shift_q;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      s_cnt_q <= '0;
      b_cnt_q <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rxd};
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      b_cnt_q <= b_cnt_d;
      shift_q <= shift_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_valid  = valid_q;
  assign rx_data   = data_q;
  assign rx_done   = done_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level reference model checked every cycle, table vectors and corner sequences.
module tb_uart_rx;

  localparam int CLK_FREQ  = 1_600_000;
  localparam int BAUD      = 100_000;
  localparam int OS        = 16;
  localparam int BIT_CLK   = 16;
  localparam int FRAME_CLK = 10 * BIT_CLK;
  // 2 clk synchroniser + 1 clk start detect + 9.5 bit periods to the stop sample
  localparam int DONE_OFS  = 3 + (19 * BIT_CLK) / 2;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_rdy = 1'b0;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_done, frame_err, overrun;

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OS)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rxd      (rxd),
    .rx_rdy   (rx_rdy),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: each sent frame schedules its outcome at a fixed offset from its start edge.
  typedef struct {
    int         due;
    logic [7:0] b;
    bit         ok;
  } ev_t;

  ev_t        evq[$];
  bit         m_valid = 0, m_done = 0, m_ferr = 0, m_ovr = 0;
  logic [7:0] m_data = '0, m_pend = '0;

  int         n_done = 0, n_ferr = 0, n_ovr = 0, n_vcyc = 0;
  logic [7:0] last_rx = '0;

  always @(negedge clk) begin
    bit  nv;
    ev_t e;
    m_done = 0;
    m_ferr = 0;
    if (!rstn) begin
      m_valid = 0;
      m_ovr   = 0;
      m_data  = '0;
      evq.delete();
    end else if (evq.size() > 0 && evq[0].due == cyc) begin
      e      = evq.pop_front();
      m_pend = e.b;
      m_done = e.ok;
      m_ferr = !e.ok;
    end
    check("rx_valid", rx_valid, m_valid);
    check("rx_done", rx_done, m_done);
    check("frame_err", frame_err, m_ferr);
    check("overrun", overrun, m_ovr);
    if (m_valid) check("rx_data", rx_data, m_data);

    if (rx_done)   n_done++;
    if (frame_err) n_ferr++;
    if (overrun)   n_ovr++;
    if (rx_valid) begin
      n_vcyc++;
      last_rx = rx_data;
    end

    if (rstn) begin
      nv    = m_valid && !rx_rdy;
      m_ovr = 0;
      if (m_done) begin
        if (!m_valid || rx_rdy) begin
          nv     = 1;
          m_data = m_pend;
        end else begin
          m_ovr = 1;
        end
      end
      m_valid = nv;
    end
  end

  task automatic send_frame(input logic [7:0] b, input bit ok, input bit rnd_rdy,
                            input int rdy_pulse_j, input int rst_j);
    logic [9:0] fr;
    ev_t        e;
    fr = {ok, b, 1'b0};
    for (int j = 0; j < FRAME_CLK; j++) begin
      @(posedge clk);
      #1;
      if (j == 0) begin
        e.due = cyc + DONE_OFS;
        e.b   = b;
        e.ok  = ok;
        evq.push_back(e);
      end
      rxd = fr[j / BIT_CLK];
      if (rnd_rdy) rx_rdy = ($urandom_range(0, 1) == 1);
      if (rdy_pulse_j >= 0 && j == rdy_pulse_j)     rx_rdy = 1'b1;
      if (rdy_pulse_j >= 0 && j == rdy_pulse_j + 1) rx_rdy = 1'b0;
      if (rst_j >= 0 && j == rst_j) begin
        rstn = 1'b0;
        #1;
        check("rst_valid", rx_valid, 1'b0);
        check("rst_data", rx_data, 8'h00);
        check("rst_done", rx_done, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_ovr", overrun, 1'b0);
      end
      if (rst_j >= 0 && j == rst_j + 3) rstn = 1'b1;
    end
  endtask

  task automatic idle(input int n, input bit rnd_rdy);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rxd = 1'b1;
      if (rnd_rdy) rx_rdy = ($urandom_range(0, 1) == 1);
    end
  endtask

  typedef struct {
    logic [7:0] b;
    bit         ok;
    int         exp_done;
    int         exp_ferr;
    int         exp_vcyc;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #600_000;
    $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, f0, o0, v0;
    logic [7:0] rb;
    bit         rok;

    tbl[0] = '{8'hA5, 1'b1, 1, 0, 1, 8'hA5};
    tbl[1] = '{8'h3C, 1'b0, 0, 1, 0, 8'h00};
    tbl[2] = '{8'h55, 1'b1, 1, 0, 1, 8'h55};
    tbl[3] = '{8'h00, 1'b1, 1, 0, 1, 8'h00};
    tbl[4] = '{8'hFF, 1'b1, 1, 0, 1, 8'hFF};
    tbl[5] = '{8'h81, 1'b1, 1, 0, 1, 8'h81};

    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", rx_valid, 1'b0);
    check("reset_data", rx_data, 8'h00);
    rstn = 1'b1;
    idle(4, 0);

    // Clean frames and a framing error, consumer always ready
    rx_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d0 = n_done; f0 = n_ferr; v0 = n_vcyc;
      send_frame(tbl[i].b, tbl[i].ok, 0, -1, -1);
      idle(24, 0);
      check("tbl_done", n_done - d0, tbl[i].exp_done);
      check("tbl_ferr", n_ferr - f0, tbl[i].exp_ferr);
      check("tbl_vcyc", n_vcyc - v0, tbl[i].exp_vcyc);
      if (tbl[i].exp_done > 0) check("tbl_data", last_rx, tbl[i].exp_data);
    end

    // Start-bit glitch shorter than half a bit
    d0 = n_done; f0 = n_ferr; v0 = n_vcyc;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      rxd = 1'b0;
    end
    idle(30, 0);
    check("glitch_done", n_done - d0, 0);
    check("glitch_ferr", n_ferr - f0, 0);
    check("glitch_vcyc", n_vcyc - v0, 0);

    // Overrun: consumer stalled across two back-to-back frames
    rx_rdy = 1'b0;
    o0 = n_ovr;
    send_frame(8'h11, 1'b1, 0, -1, -1);
    send_frame(8'h22, 1'b1, 0, -1, -1);
    idle(8, 0);
    check("ovr_valid", rx_valid, 1'b1);
    check("ovr_data", rx_data, 8'h11);
    check("ovr_count", n_ovr - o0, 1);
    @(posedge clk);
    #1 rx_rdy = 1'b1;
    @(posedge clk);
    #1 rx_rdy = 1'b0;
    check("ovr_drain", rx_valid, 1'b0);

    // Same-cycle consume and refill
    o0 = n_ovr;
    send_frame(8'h01, 1'b1, 0, -1, -1);
    send_frame(8'h02, 1'b1, 0, DONE_OFS, -1);
    idle(8, 0);
    check("refill_valid", rx_valid, 1'b1);
    check("refill_data", rx_data, 8'h02);
    check("refill_ovr", n_ovr - o0, 0);

    // Reset in the middle of data bit 4, then a clean frame
    send_frame(8'hF0, 1'b1, 0, -1, 5 * BIT_CLK + 4);
    idle(10, 0);
    check("post_rst_valid", rx_valid, 1'b0);
    rx_rdy = 1'b1;
    d0 = n_done;
    send_frame(8'h0F, 1'b1, 0, -1, -1);
    idle(8, 0);
    check("post_rst_done", n_done - d0, 1);
    check("post_rst_data", last_rx, 8'h0F);

    // Random bytes, occasional bad stop bits, random consumer readiness
    for (int i = 0; i < 40; i++) begin
      rb  = 8'($urandom);
      rok = ($urandom_range(0, 9) != 0);
      send_frame(rb, rok, 1, -1, -1);
      idle(rok ? $urandom_range(0, 12) : 24, 1);
    end
    rx_rdy = 1'b1;
    idle(20, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver with 16x oversampling. It converts the serial line rxd into bytes.
- Sits directly upstream of the 8-entry loopback byte buffer. Each received byte is presented on a valid/ready handshake to the buffer's receive port.
- Also produces the end-of-frame pulse rx_done and error flags for status logic.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 115_200, line rate in bit/s.
- OVERSAMPLE, 16, ticks per bit period; must be even and at least 8.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- rxd  input  1  asynchronous serial line; idles high.
- rx_rdy  input  1  consumer can accept a byte (the buffer's r_rdy).
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_data  output  8  received byte, LSB received first.
- rx_done  output  1  one-cycle pulse when a valid stop bit is sampled.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- overrun  output  1  one-cycle pulse when a completed byte is dropped.

Behaviour:
- Reset: asynchronous, active-low reset on rstn; clock clk.
  - All outputs reset to 0.
  - Synchroniser flops reset to 1.
  - FSM resets to IDLE; all counters reset to 0.
  - Asserting reset mid-frame aborts the frame immediately. No partial byte is ever presented.
- Synchroniser: rxd passes through two flops to give rxd_s. All sampling uses rxd_s.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer division. Elaboration error if DIV < 1.
  - Free-running counter 0..DIV-1. tick is high for one cycle when the counter equals DIV-1; with DIV=1, tick is high every cycle.
- Sample counter s_cnt and bit counter b_cnt (0..7) advance only on tick.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - On a tick with rxd_s=0: go to START, s_cnt := 0.
  - Otherwise remain in IDLE.
- START:
  - On the tick where s_cnt reaches OVERSAMPLE/2-1 (mid start bit), re-check rxd_s.
  - If rxd_s=1: false start, return to IDLE with no outputs.
  - If rxd_s=0: s_cnt := 0, b_cnt := 0, go to DATA.
- DATA:
  - On the tick where s_cnt = OVERSAMPLE-1: shift rxd_s into shift register bit 7 (right shift, so LSB first), s_cnt := 0.
  - After the shift with b_cnt=7, go to STOP; otherwise b_cnt++.
- STOP:
  - On the tick where s_cnt = OVERSAMPLE-1, sample rxd_s and return to IDLE.
  - Sample = 1: frame completes. rx_done pulses the next cycle, then the output-register rules apply.
  - Sample = 0: frame_err pulses the next cycle and the byte is discarded. rx_done is not pulsed.
  - In both cases, IDLE re-detects a held-low line on the next tick (break handling is not special-cased).
- Output register and handshake (evaluated in the cycle after the stop sample, "complete"):
  - A transfer occurs when rx_valid && rx_rdy are both high on a clock edge; rx_valid then deasserts unless refilled.
  - complete with rx_valid=0: rx_data := byte, rx_valid := 1.
  - complete with a same-cycle transfer: old byte consumed, new byte loaded, rx_valid stays 1.
  - complete with rx_valid=1 and no transfer: new byte dropped, old byte kept, overrun pulses.
  - rx_data is stable while rx_valid=1 and no transfer has occurred.
- Latency:
  - Sampling starts once the start edge reaches rxd_s, 2 clk after it appears on rxd.
  - rx_valid rises 1 clk after the tick of the stop-bit sample, which occurs ~9.5 bit periods after start detection, give or take 1 tick.
- rx_done, frame_err and overrun are each exactly one clock wide. frame_err and rx_done are never high together.

Decomposition:
- Package uart_pkg holds:
  - the state enum {IDLE, START, DATA, STOP};
  - the constant DATA_BITS=8;
  - a DIV calculation function shared with the future transmitter.
- One natural sub-module, uart_baud_tick (parameters CLK_FREQ, BAUD, OVERSAMPLE; output tick). The transmitter reuses it with OVERSAMPLE=1.

Test Plan:
Bench parameters: CLK_FREQ=1_600_000, BAUD=100_000, OVERSAMPLE=16, so DIV=1 and one bit = 16 clk.
1. Send byte 0xA5 as 8N1 with rx_rdy=1 -> rx_done pulse and rx_valid=1 with rx_data=0xA5 for exactly one cycle; no error flags.
2. Glitch: drive rxd low for 4 clk, then high -> FSM returns to IDLE; no rx_valid, rx_done or frame_err.
3. Send 0x3C with the stop bit forced low -> frame_err pulses for one cycle; rx_valid stays 0; the following clean frame 0x55 is received correctly.
4. rx_rdy=0, send 0x11 then 0x22 back to back -> rx_data holds 0x11, overrun pulses once at the 0x22 stop sample; raising rx_rdy consumes 0x11 and rx_valid falls.
5. rx_rdy=0, send 0x01; assert rx_rdy for one cycle exactly at 0x02 completion -> 0x01 consumed, rx_data=0x02, rx_valid remains 1, no overrun.
6. Pulse rstn low during bit 4 of 0xF0 -> all outputs 0 immediately; a subsequent frame 0x0F is received as 0x0F.
